// File: rtl/sha_pkg.sv
// Shared types and helpers for the SHA requester scheduler.
// FSM state encoding, hash-type constants, clog2.
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam logic SHA_256 = 1'b0;
  localparam logic SHA_512 = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha_scheduler_if.sv
// Bundle of the scheduler's requester, padder and engine signals.
// master drives requesters/engine, slave is the scheduler side.
interface sha_scheduler_if
  import sha_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512
) ();
  localparam int IW = clog2(NUM_REQ);

  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axis_tdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic [NUM_REQ-1:0]              s_axis_tvalid;
  logic [NUM_REQ-1:0]              s_axis_tlast;
  logic [NUM_REQ-1:0]              s_axis_tready;
  logic [NUM_REQ-1:0]              req_sha_type;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]         m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_tready;
  logic                            en;
  logic                            sha_type;
  logic                            digest_done;
  logic [IW-1:0]                   grant_id;
  logic                            busy;
  logic                            timeout_err;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
    output s_axis_tlast, req_sha_type, m_axis_tready,
    output digest_done,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep,
    input  m_axis_tvalid, m_axis_tlast, en, sha_type,
    input  grant_id, busy, timeout_err
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
    input  s_axis_tlast, req_sha_type, m_axis_tready,
    input  digest_done,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep,
    output m_axis_tvalid, m_axis_tlast, en, sha_type,
    output grant_id, busy, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr_i, with wrap.
// Pure combinational; the caller owns the pointer register.
module rr_arbiter
  import sha_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      gnt_o,
  output logic               any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets high to low so the closest request to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    any_o = |req_i;
    sum   = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(NUM_REQ)) sum = sum - (IW + 1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (req_i[idx]) gnt_o = idx;
    end
  end

endmodule

// File: rtl/sha_scheduler.sv
// Multiplexes requester streams onto one SHA padder/engine.
// Define SHA_SCHED_TIMEOUT_EN to enable the digest-wait watchdog.
module sha_scheduler
  import sha_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = clog2(NUM_REQ),
  localparam int KW = DATA_WIDTH / 8
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ*KW-1:0]         s_axis_tkeep,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  input  logic [NUM_REQ-1:0]            req_sha_type,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KW-1:0]                 m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          en,
  output logic                          sha_type,
  input  logic                          digest_done,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          sha_type_q, sha_type_d;
  logic [IW-1:0] arb_gnt;
  logic          arb_any;
  logic [IW-1:0] next_ptr;
  logic          timeout_hit;
  logic          last_beat;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (s_axis_tvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ?
                    '0 : grant_q + IW'(1);
  assign last_beat = s_axis_tvalid[grant_q] & m_axis_tready &
                     s_axis_tlast[grant_q];

`ifdef SHA_SCHED_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  assign timeout_hit = (state_q == ST_WAIT) &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q == ST_WAIT && !timeout_hit) ?
                 cnt_q + CW'(1) : '0;
  assign timeout_err = tmo_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= timeout_hit & ~digest_done;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      sha_type_q <= SHA_256;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      sha_type_q <= sha_type_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    sha_type_d = sha_type_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d    = ST_STREAM;
          grant_d    = arb_gnt;
          sha_type_d = req_sha_type[arb_gnt] ? SHA_512 : SHA_256;
        end
      end
      ST_STREAM: begin
        if (last_beat) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (digest_done || timeout_hit) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Routing is combinational so a stalled tready stalls the requester.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state_q == ST_STREAM) begin
      m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
      m_axis_tvalid = s_axis_tvalid[grant_q];
      m_axis_tlast  = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
    en       = (state_q != ST_IDLE);
    busy     = (state_q != ST_IDLE);
    grant_id = grant_q;
    sha_type = sha_type_q;
  end

endmodule

// File: tb/tb_sha_scheduler.sv
// Self-checking bench for sha_scheduler: vector table, scoreboard,
// and directed multi-cycle sequences.
module tb_sha_scheduler;
  import sha_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  logic dd_auto = 1'b0;
  logic dd_man  = 1'b0;
  assign bus.digest_done = dd_auto | dd_man;

  sha_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis_tdata  (bus.s_axis_tdata),
    .s_axis_tkeep  (bus.s_axis_tkeep),
    .s_axis_tvalid (bus.s_axis_tvalid),
    .s_axis_tlast  (bus.s_axis_tlast),
    .req_sha_type  (bus.req_sha_type),
    .s_axis_tready (bus.s_axis_tready),
    .m_axis_tdata  (bus.m_axis_tdata),
    .m_axis_tkeep  (bus.m_axis_tkeep),
    .m_axis_tvalid (bus.m_axis_tvalid),
    .m_axis_tlast  (bus.m_axis_tlast),
    .m_axis_tready (bus.m_axis_tready),
    .en            (bus.en),
    .sha_type      (bus.sha_type),
    .digest_done   (bus.digest_done),
    .grant_id      (bus.grant_id),
    .busy          (bus.busy),
    .timeout_err   (bus.timeout_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] typ;
    int           grant;
    logic         etype;
  } vec_t;

  beat_t sb_q[$];
  beat_t exp_b;
  vec_t  tv[8];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    auto_dig = 1'b0;
  int    idle_cnt = 0;
  int    last_idle = 0;

  function automatic logic [DW-1:0] tag(int r, int s, int b);
    return {8'hA5, 8'(r), 8'(s), 8'(b)};
  endfunction

  function automatic beat_t mk(int r, int s, int b, int n);
    beat_t x;
    x.data = tag(r, s, b);
    x.keep = (b == n - 1) ? 4'h7 : 4'hF;
    x.last = (b == n - 1);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_msg(input int r, input int s, input int n);
    for (int b = 0; b < n; b++) sb_q.push_back(mk(r, s, b, n));
  endtask

  task automatic send_msg(input int r, input int n, input logic typ,
                          input int s, input int gap, input bit push);
    int guard;
    bit acc;
    bus.req_sha_type[r] = typ;
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x = mk(r, s, b, n);
      if (push) sb_q.push_back(x);
      bus.s_axis_tdata[r*DW +: DW] = x.data;
      bus.s_axis_tkeep[r*KW +: KW] = x.keep;
      bus.s_axis_tlast[r] = x.last;
      bus.s_axis_tvalid[r] = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.s_axis_tready[r];
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 300) begin
          chk("send_timeout", 64'(0), 64'(1));
          bus.s_axis_tvalid[r] = 1'b0;
          return;
        end
      end
      if (b == gap) begin
        bus.s_axis_tvalid[r] = 1'b0;
        tick(2);
      end
    end
    bus.s_axis_tvalid[r] = 1'b0;
    bus.s_axis_tlast[r] = 1'b0;
  endtask

  // Scoreboard: every accepted padder beat must match the queue head.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 bus.m_axis_tdata);
      end else begin
        exp_b = sb_q.pop_front();
        chk("sb_data", 64'(bus.m_axis_tdata), 64'(exp_b.data));
        chk("sb_keep", 64'(bus.m_axis_tkeep), 64'(exp_b.keep));
        chk("sb_last", 64'(bus.m_axis_tlast), 64'(exp_b.last));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_dig && rst_n && bus.m_axis_tvalid &&
        bus.m_axis_tready && bus.m_axis_tlast) begin
      tick(2);
      dd_auto = 1'b1;
      tick();
      dd_auto = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!bus.busy) idle_cnt++;
    else begin
      if (idle_cnt != 0) last_idle = idle_cnt;
      idle_cnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{4'b0100, 4'b0000, 2, 1'b0};
    tv[1] = '{4'b0011, 4'b0010, 0, 1'b0};
    tv[2] = '{4'b0011, 4'b0010, 1, 1'b1};
    tv[3] = '{4'b1001, 4'b1000, 3, 1'b1};
    tv[4] = '{4'b1111, 4'b0001, 0, 1'b1};
    tv[5] = '{4'b1100, 4'b0000, 2, 1'b0};
    tv[6] = '{4'b0001, 4'b0001, 0, 1'b1};
    tv[7] = '{4'b1010, 4'b0000, 1, 1'b0};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tvalid = '1;
    bus.s_axis_tlast  = '0;
    bus.req_sha_type  = '0;
    bus.m_axis_tready = 1'b1;

    #12;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_en", 64'(bus.en), 64'(0));
    chk("rst_grant", 64'(bus.grant_id), 64'(0));
    chk("rst_type", 64'(bus.sha_type), 64'(0));
    chk("rst_tready", 64'(bus.s_axis_tready), 64'(0));
    chk("rst_mvalid", 64'(bus.m_axis_tvalid), 64'(0));
    chk("rst_terr", 64'(bus.timeout_err), 64'(0));
    bus.s_axis_tvalid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < N; r++) bus.s_axis_tdata[r*DW +: DW] = tag(r, i, 0);
      bus.s_axis_tkeep  = {N{4'h7}};
      bus.s_axis_tlast  = '1;
      bus.req_sha_type  = tv[i].typ;
      bus.s_axis_tvalid = tv[i].mask;
      sb_q.push_back(mk(tv[i].grant, i, 0, 1));
      tick();
      chk("tv_grant", 64'(bus.grant_id), 64'(tv[i].grant));
      chk("tv_type", 64'(bus.sha_type), 64'(tv[i].etype));
      chk("tv_busy", 64'(bus.busy), 64'(1));
      chk("tv_en", 64'(bus.en), 64'(1));
      chk("tv_tready", 64'(bus.s_axis_tready), 64'(N'(1) << tv[i].grant));
      chk("tv_mvalid", 64'(bus.m_axis_tvalid), 64'(1));
      tick();
      bus.s_axis_tvalid = '0;
      chk("tv_wait_busy", 64'(bus.busy), 64'(1));
      chk("tv_wait_tready", 64'(bus.s_axis_tready), 64'(0));
      chk("tv_wait_mvalid", 64'(bus.m_axis_tvalid), 64'(0));
      dd_man = 1'b1;
      tick();
      dd_man = 1'b0;
      chk("tv_idle_busy", 64'(bus.busy), 64'(0));
      chk("tv_idle_en", 64'(bus.en), 64'(0));
    end
    bus.s_axis_tlast = '0;
    bus.req_sha_type = '0;

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();

    // Requester 2 alone, three beats, engine answers late.
    fork
      send_msg(2, 3, 1'b0, 20, -1, 1'b1);
      begin
        tick();
        chk("r2_en", 64'(bus.en), 64'(1));
        chk("r2_grant", 64'(bus.grant_id), 64'(2));
      end
    join
    chk("r2_wait_busy", 64'(bus.busy), 64'(1));
    chk("r2_wait_mvalid", 64'(bus.m_axis_tvalid), 64'(0));
    tick(3);
    chk("r2_hold_busy", 64'(bus.busy), 64'(1));
    chk("r2_hold_grant", 64'(bus.grant_id), 64'(2));
    dd_man = 1'b1;
    tick();
    dd_man = 1'b0;
    chk("r2_done_busy", 64'(bus.busy), 64'(0));

    // rr_ptr now 3: requester 3 beats requester 0.
    auto_dig = 1'b1;
    push_msg(3, 21, 1);
    push_msg(0, 22, 1);
    fork
      send_msg(0, 1, 1'b0, 22, -1, 1'b0);
      send_msg(3, 1, 1'b1, 21, -1, 1'b0);
    join
    tick(4);
    chk("rr_done_busy", 64'(bus.busy), 64'(0));

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();

    push_msg(0, 30, 2);
    push_msg(1, 31, 2);
    fork
      send_msg(0, 2, 1'b0, 30, -1, 1'b0);
      send_msg(1, 2, 1'b1, 31, -1, 1'b0);
    join
    chk("b2b_idle_gap", 64'(last_idle), 64'(1));
    tick(4);

    auto_dig = 1'b0;
    fork
      send_msg(1, 1, 1'b1, 40, -1, 1'b1);
      begin
        tick();
        chk("one_type", 64'(bus.sha_type), 64'(SHA_512));
      end
    join
    chk("one_wait_busy", 64'(bus.busy), 64'(1));
    chk("one_wait_mvalid", 64'(bus.m_axis_tvalid), 64'(0));
    dd_man = 1'b1;
    tick();
    dd_man = 1'b0;

    // Padder back-pressure plus a requester valid gap.
    auto_dig = 1'b1;
    fork
      send_msg(2, 6, 1'b0, 50, 3, 1'b1);
      begin
        tick(3);
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("bp_tready", 64'(bus.s_axis_tready), 64'(0));
          chk("bp_mvalid", 64'(bus.m_axis_tvalid), 64'(1));
          tick();
        end
        bus.m_axis_tready = 1'b1;
      end
    join
    tick(4);
    chk("bp_done_busy", 64'(bus.busy), 64'(0));
    chk("bp_sb_empty", 64'(sb_q.size()), 64'(0));
    auto_dig = 1'b0;

    dd_man = 1'b1;
    tick();
    dd_man = 1'b0;
    chk("dd_idle_busy", 64'(bus.busy), 64'(0));
    chk("dd_idle_en", 64'(bus.en), 64'(0));

    bus.req_sha_type[3] = 1'b1;
    bus.s_axis_tdata[3*DW +: DW] = tag(3, 60, 0);
    bus.s_axis_tkeep[3*KW +: KW] = 4'hF;
    bus.s_axis_tlast[3] = 1'b0;
    bus.s_axis_tvalid[3] = 1'b1;
    push_msg(3, 60, 3);
    void'(sb_q.pop_back());
    tick();
    chk("dd_st_grant", 64'(bus.grant_id), 64'(3));
    tick();
    bus.s_axis_tdata[3*DW +: DW] = tag(3, 60, 1);
    dd_man = 1'b1;
    tick();
    dd_man = 1'b0;
    chk("dd_st_busy", 64'(bus.busy), 64'(1));
    chk("dd_st_grant2", 64'(bus.grant_id), 64'(3));
    chk("dd_st_mvalid", 64'(bus.m_axis_tvalid), 64'(1));
    chk("dd_st_tready", 64'(bus.s_axis_tready), 64'(4'b1000));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_en", 64'(bus.en), 64'(0));
    chk("mid_rst_grant", 64'(bus.grant_id), 64'(0));
    chk("mid_rst_type", 64'(bus.sha_type), 64'(0));
    chk("mid_rst_tready", 64'(bus.s_axis_tready), 64'(0));
    chk("mid_rst_mvalid", 64'(bus.m_axis_tvalid), 64'(0));
    chk("mid_rst_mdata", 64'(bus.m_axis_tdata), 64'(0));
    chk("mid_rst_terr", 64'(bus.timeout_err), 64'(0));
    chk("mid_rst_sb", 64'(sb_q.size()), 64'(0));
    bus.s_axis_tvalid = '0;
    bus.req_sha_type = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("no_replay_busy", 64'(bus.busy), 64'(0));

    send_msg(0, 1, 1'b0, 70, -1, 1'b1);
`ifdef SHA_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk("tmo_early_err", 64'(bus.timeout_err), 64'(0));
        chk("tmo_early_busy", 64'(bus.busy), 64'(1));
      end else begin
        chk("tmo_err", 64'(bus.timeout_err), 64'(1));
        chk("tmo_busy", 64'(bus.busy), 64'(0));
      end
    end
    tick();
    chk("tmo_err_pulse", 64'(bus.timeout_err), 64'(0));
`else
    tick(40);
    chk("notmo_busy", 64'(bus.busy), 64'(1));
    chk("notmo_err", 64'(bus.timeout_err), 64'(0));
    dd_man = 1'b1;
    tick();
    dd_man = 1'b0;
    chk("notmo_done", 64'(bus.busy), 64'(0));
`endif

    tick(2);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
